slv_mux_fsm: RTL and testbench

//  Next-generation register-slave access FSM. Accepts one master request, routes it to one of N_SLV

---
 rtl/slv_fsm_pkg.sv | 25 ++
 rtl/slv_onehot_mux.sv | 30 +++
 rtl/slv_mux_fsm.sv | 165 ++++++++++++++++
 tb/tb_slv_mux_fsm.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slv_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : slv_fsm_pkg
// Brief   : Shared state encoding and error-cause type for the register-slave
//           access FSM.
// Revision: 1.0
// ============================================================================
package slv_fsm_pkg;

   typedef logic [1:0] state_e;

   localparam state_e S_IDLE = 2'd0;
   localparam state_e S_REQ  = 2'd1;
   localparam state_e S_ACK  = 2'd2;
   localparam state_e S_RESP = 2'd3;

   // Why the current response carries an error; kept for debug visibility.
   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_MISS    = 2'd1,
      ERR_TIMEOUT = 2'd2
   } err_cause_e;

endpackage
`default_nettype wire

// File: rtl/slv_onehot_mux.sv
`default_nettype none
// ============================================================================
// Module  : slv_onehot_mux
// Brief   : Selects one slave's read data from a packed bus; if several select
//           bits are set the lowest one wins.
// Revision: 1.0
// ============================================================================
module slv_onehot_mux
   import slv_fsm_pkg::*;
#(
   parameter int N_SLV      = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic [N_SLV-1:0]            i_sel,
   input  logic [N_SLV*DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0]       o_data
);

   // Walk from the top down so the lowest set bit is the last assignment.
   always_comb begin
      o_data = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if (i_sel[i]) begin
            o_data = i_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/slv_mux_fsm.sv
`default_nettype none
// ============================================================================
// Module  : slv_mux_fsm
// Brief   : Register-slave access FSM. Routes one master request to a one-hot
//           selected slave channel and returns a held, error-tagged response.
// Revision: 1.0
// ============================================================================
module slv_mux_fsm
   import slv_fsm_pkg::*;
#(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 32,
   parameter int N_SLV          = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mst__fsm__req_vld,
   output logic                        fsm__mst__req_rdy,
   input  logic                        mst__fsm__wr_en,
   input  logic                        mst__fsm__rd_en,
   input  logic [ADDR_WIDTH-1:0]       mst__fsm__addr,
   input  logic [DATA_WIDTH-1:0]       mst__fsm__wr_data,
   input  logic                        mst__fsm__sync_reset,
   input  logic [N_SLV-1:0]            dec__fsm__slv_sel,
   input  logic                        dec__fsm__miss,
   output logic                        fsm__mst__ack_vld,
   input  logic                        mst__fsm__ack_rdy,
   output logic [DATA_WIDTH-1:0]       fsm__mst__rd_data,
   output logic                        fsm__mst__err,
   output logic [N_SLV-1:0]            fsm__slv__req_vld,
   input  logic [N_SLV-1:0]            slv__fsm__req_rdy,
   output logic [ADDR_WIDTH-1:0]       fsm__slv__addr,
   output logic [DATA_WIDTH-1:0]       fsm__slv__wr_data,
   output logic                        fsm__slv__wr_en,
   output logic                        fsm__slv__rd_en,
   input  logic [N_SLV-1:0]            slv__fsm__ack_vld,
   input  logic [N_SLV*DATA_WIDTH-1:0] slv__fsm__rd_data,
   output logic [N_SLV-1:0]            fsm__slv__ack_rdy,
   output logic                        fsm__slv__sync_reset
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic             c_TO_EN   = (TIMEOUT_CYCLES > 0);

   state_e                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic                  r_wr_en;
   logic                  r_rd_en;
   logic [N_SLV-1:0]      r_sel;
   logic [DATA_WIDTH-1:0] r_rd_data;
   err_cause_e            r_err_cause;
   logic [CNT_W-1:0]      r_cnt;

   logic [N_SLV-1:0]      w_dec_low;
   logic                  w_dec_bad;
   logic                  w_req_hs;
   logic                  w_ack_hs;
   logic                  w_timeout;
   logic                  w_slv_active;
   logic [DATA_WIDTH-1:0] w_mux_data;

   // Isolate the lowest set bit so a multi-hot decode still targets one slave.
   assign w_dec_low    = dec__fsm__slv_sel & (~dec__fsm__slv_sel + N_SLV'(1));
   assign w_dec_bad    = dec__fsm__miss || (dec__fsm__slv_sel == '0);
   assign w_req_hs     = |(fsm__slv__req_vld & slv__fsm__req_rdy);
   assign w_ack_hs     = |(r_sel & slv__fsm__ack_vld);
   assign w_timeout    = c_TO_EN && (r_cnt == c_TO_LAST);
   assign w_slv_active = (r_state == S_REQ) || (r_state == S_ACK);

   slv_onehot_mux #(
      .N_SLV      (N_SLV),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rd_mux (
      .i_sel  (r_sel),
      .i_data (slv__fsm__rd_data),
      .o_data (w_mux_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wr_data   <= '0;
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_sel       <= '0;
         r_rd_data   <= '0;
         r_err_cause <= ERR_NONE;
         r_cnt       <= '0;
      end else if (mst__fsm__sync_reset) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wr_data   <= '0;
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_sel       <= '0;
         r_rd_data   <= '0;
         r_err_cause <= ERR_NONE;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mst__fsm__req_vld) begin
                  r_addr    <= mst__fsm__addr;
                  r_wr_data <= mst__fsm__wr_data;
                  r_wr_en   <= mst__fsm__wr_en;
                  r_rd_en   <= mst__fsm__rd_en;
                  r_rd_data <= '0;
                  r_cnt     <= '0;
                  if (w_dec_bad) begin
                     r_sel       <= '0;
                     r_err_cause <= ERR_MISS;
                     r_state     <= S_RESP;
                  end else begin
                     r_sel       <= w_dec_low;
                     r_err_cause <= ERR_NONE;
                     r_state     <= S_REQ;
                  end
               end
            end
            S_REQ, S_ACK: begin
               // The counter saturates, so a late request handshake still times out in ACK.
               if (r_cnt != c_TO_LAST) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
               if ((r_state == S_REQ) && w_req_hs) begin
                  r_state <= S_ACK;
               end else if ((r_state == S_ACK) && w_ack_hs) begin
                  r_rd_data   <= w_mux_data;
                  r_err_cause <= ERR_NONE;
                  r_state     <= S_RESP;
               end else if (w_timeout) begin
                  r_rd_data   <= '0;
                  r_err_cause <= ERR_TIMEOUT;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (mst__fsm__ack_rdy) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign fsm__mst__req_rdy    = (r_state == S_IDLE) && !mst__fsm__sync_reset;
   assign fsm__mst__ack_vld    = (r_state == S_RESP);
   assign fsm__mst__rd_data    = (r_state == S_RESP) ? r_rd_data : '0;
   assign fsm__mst__err        = (r_state == S_RESP) && (r_err_cause != ERR_NONE);
   assign fsm__slv__req_vld    = (r_state == S_REQ) ? r_sel : '0;
   assign fsm__slv__addr       = w_slv_active ? r_addr : '0;
   assign fsm__slv__wr_data    = w_slv_active ? r_wr_data : '0;
   assign fsm__slv__wr_en      = w_slv_active && r_wr_en;
   assign fsm__slv__rd_en      = w_slv_active && r_rd_en;
   // Unselected channels always accept acks so stale responses drain away.
   assign fsm__slv__ack_rdy    = ((r_state == S_REQ) || (r_state == S_RESP)) ? ~r_sel : '1;
   assign fsm__slv__sync_reset = mst__fsm__sync_reset;

endmodule
`default_nettype wire

// File: tb/tb_slv_mux_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_slv_mux_fsm
// Brief   : Self-checking bench for slv_mux_fsm: randomized transactions with a
//           transaction-timeline reference model plus directed scenarios.
// Revision: 1.0
// ============================================================================
module tb_slv_mux_fsm;

   localparam int AW = 64;
   localparam int DW = 32;
   localparam int NS = 4;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              mst__fsm__req_vld, fsm__mst__req_rdy;
   logic              mst__fsm__wr_en, mst__fsm__rd_en;
   logic [AW-1:0]     mst__fsm__addr;
   logic [DW-1:0]     mst__fsm__wr_data;
   logic              mst__fsm__sync_reset;
   logic [NS-1:0]     dec__fsm__slv_sel;
   logic              dec__fsm__miss;
   logic              fsm__mst__ack_vld, mst__fsm__ack_rdy;
   logic [DW-1:0]     fsm__mst__rd_data;
   logic              fsm__mst__err;
   logic [NS-1:0]     fsm__slv__req_vld, slv__fsm__req_rdy;
   logic [AW-1:0]     fsm__slv__addr;
   logic [DW-1:0]     fsm__slv__wr_data;
   logic              fsm__slv__wr_en, fsm__slv__rd_en;
   logic [NS-1:0]     slv__fsm__ack_vld;
   logic [NS*DW-1:0]  slv__fsm__rd_data;
   logic [NS-1:0]     fsm__slv__ack_rdy;
   logic              fsm__slv__sync_reset;

   always #5 clk = ~clk;

   slv_mux_fsm #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SLV(NS), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .mst__fsm__req_vld(mst__fsm__req_vld), .fsm__mst__req_rdy(fsm__mst__req_rdy),
      .mst__fsm__wr_en(mst__fsm__wr_en), .mst__fsm__rd_en(mst__fsm__rd_en),
      .mst__fsm__addr(mst__fsm__addr), .mst__fsm__wr_data(mst__fsm__wr_data),
      .mst__fsm__sync_reset(mst__fsm__sync_reset),
      .dec__fsm__slv_sel(dec__fsm__slv_sel), .dec__fsm__miss(dec__fsm__miss),
      .fsm__mst__ack_vld(fsm__mst__ack_vld), .mst__fsm__ack_rdy(mst__fsm__ack_rdy),
      .fsm__mst__rd_data(fsm__mst__rd_data), .fsm__mst__err(fsm__mst__err),
      .fsm__slv__req_vld(fsm__slv__req_vld), .slv__fsm__req_rdy(slv__fsm__req_rdy),
      .fsm__slv__addr(fsm__slv__addr), .fsm__slv__wr_data(fsm__slv__wr_data),
      .fsm__slv__wr_en(fsm__slv__wr_en), .fsm__slv__rd_en(fsm__slv__rd_en),
      .slv__fsm__ack_vld(slv__fsm__ack_vld), .slv__fsm__rd_data(slv__fsm__rd_data),
      .fsm__slv__ack_rdy(fsm__slv__ack_rdy), .fsm__slv__sync_reset(fsm__slv__sync_reset)
   );

   int n_chk  = 0;
   int n_pass = 0;
   logic chk_en = 1'b0;

   // Expected outputs for the current cycle, set by the stimulus from the transaction timeline.
   logic          e_req_rdy, e_ack_vld, e_err, e_wr_en, e_rd_en;
   logic [DW-1:0] e_rd_data, e_wr_data;
   logic [AW-1:0] e_addr;
   logic [NS-1:0] e_slv_req_vld, e_slv_ack_rdy;

   // Properties of the transaction in flight.
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wd;
   logic          t_we;
   logic [NS-1:0] t_oh;

   // Observations pinned against hand-computed literals.
   int            cyc = 0, acc_cyc = 0, ack_cyc = -1, req_hi_cnt = 0, ack_hi_cnt = 0;
   logic [DW-1:0] ack_data = '0;
   logic          ack_err = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         chk("req_rdy",       64'(fsm__mst__req_rdy),    64'(e_req_rdy));
         chk("ack_vld",       64'(fsm__mst__ack_vld),    64'(e_ack_vld));
         chk("mst_rd_data",   64'(fsm__mst__rd_data),    64'(e_rd_data));
         chk("mst_err",       64'(fsm__mst__err),        64'(e_err));
         chk("slv_req_vld",   64'(fsm__slv__req_vld),    64'(e_slv_req_vld));
         chk("slv_ack_rdy",   64'(fsm__slv__ack_rdy),    64'(e_slv_ack_rdy));
         chk("slv_addr",      64'(fsm__slv__addr),       64'(e_addr));
         chk("slv_wr_data",   64'(fsm__slv__wr_data),    64'(e_wr_data));
         chk("slv_wr_en",     64'(fsm__slv__wr_en),      64'(e_wr_en));
         chk("slv_rd_en",     64'(fsm__slv__rd_en),      64'(e_rd_en));
         chk("slv_sync_rst",  64'(fsm__slv__sync_reset), 64'(mst__fsm__sync_reset));
         chk("req_vld_onehot", 64'($onehot0(fsm__slv__req_vld)), 64'(1));
      end
      if (!rst && fsm__mst__req_rdy && mst__fsm__req_vld) begin
         acc_cyc    = cyc;
         ack_cyc    = -1;
         req_hi_cnt = 0;
         ack_hi_cnt = 0;
      end else begin
         if (fsm__slv__req_vld != '0) req_hi_cnt++;
         if (fsm__mst__ack_vld) begin
            ack_hi_cnt++;
            if (ack_cyc < 0) begin
               ack_cyc  = cyc;
               ack_data = fsm__mst__rd_data;
               ack_err  = fsm__mst__err;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Random values on every input; callers then pin what the scenario needs.
   task automatic background();
      mst__fsm__req_vld    = 1'($urandom);
      mst__fsm__wr_en      = 1'($urandom);
      mst__fsm__rd_en      = 1'($urandom);
      mst__fsm__addr       = {$urandom, $urandom};
      mst__fsm__wr_data    = $urandom;
      mst__fsm__sync_reset = 1'b0;
      dec__fsm__slv_sel    = NS'($urandom);
      dec__fsm__miss       = 1'($urandom);
      mst__fsm__ack_rdy    = 1'($urandom);
      slv__fsm__req_rdy    = NS'($urandom);
      slv__fsm__ack_vld    = NS'($urandom);
      for (int i = 0; i < NS; i++) slv__fsm__rd_data[i*DW +: DW] = $urandom;
   endtask

   task automatic exp_idle();
      e_req_rdy = !mst__fsm__sync_reset;
      e_ack_vld = 1'b0; e_rd_data = '0; e_err = 1'b0;
      e_slv_req_vld = '0; e_slv_ack_rdy = '1;
      e_addr = '0; e_wr_data = '0; e_wr_en = 1'b0; e_rd_en = 1'b0;
   endtask

   task automatic exp_slv(input logic in_req);
      e_req_rdy = 1'b0;
      e_ack_vld = 1'b0; e_rd_data = '0; e_err = 1'b0;
      e_slv_req_vld = in_req ? t_oh : '0;
      e_slv_ack_rdy = in_req ? ~t_oh : '1;
      e_addr = t_addr; e_wr_data = t_wd; e_wr_en = t_we; e_rd_en = !t_we;
   endtask

   task automatic exp_resp(input logic [DW-1:0] rd, input logic er);
      e_req_rdy = 1'b0;
      e_ack_vld = 1'b1; e_rd_data = rd; e_err = er;
      e_slv_req_vld = '0; e_slv_ack_rdy = ~t_oh;
      e_addr = '0; e_wr_data = '0; e_wr_en = 1'b0; e_rd_en = 1'b0;
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         background();
         mst__fsm__sync_reset = ($urandom_range(0, 7) == 0);
         mst__fsm__req_vld    = mst__fsm__sync_reset;
         exp_idle();
         tick();
      end
   endtask

   // One master transaction. d1: cycles in REQ before the slave is ready, d2: cycles in
   // ACK before the slave acks (-1 = never), d3: cycles the master holds off ack_rdy.
   // A slave access may spend TO cycles in REQ+ACK; a handshake in the last one still counts.
   task automatic run_txn(input logic [NS-1:0] sel, input logic miss, input logic we,
                          input int d1, input int d2, input int d3, input logic [DW-1:0] rdv);
      int idx, k, j;
      logic bad, hs, to;
      logic [DW-1:0] e_rd;
      logic e_e;
      idx = -1;
      for (int i = NS - 1; i >= 0; i--) if (sel[i]) idx = i;
      bad  = miss || (idx < 0);
      t_oh = bad ? '0 : (NS'(1) << idx);
      background();
      mst__fsm__req_vld = 1'b1; mst__fsm__wr_en = we; mst__fsm__rd_en = !we;
      dec__fsm__slv_sel = sel;  dec__fsm__miss  = miss;
      t_addr = mst__fsm__addr; t_wd = mst__fsm__wr_data; t_we = we;
      exp_idle();
      tick();
      e_rd = '0; e_e = 1'b1;
      if (!bad) begin
         k = 0; hs = 1'b0; to = 1'b0;
         while (!hs && !to) begin
            background();
            slv__fsm__req_rdy[idx] = (k == d1);
            exp_slv(1'b1);
            hs = (k == d1);
            to = !hs && (k == TO - 1);
            tick(); k++;
         end
         if (hs) begin
            j = 0; hs = 1'b0;
            while (!hs && !to) begin
               background();
               slv__fsm__ack_vld[idx] = (j == d2);
               if (j == d2) slv__fsm__rd_data[idx*DW +: DW] = rdv;
               exp_slv(1'b0);
               hs = (j == d2);
               to = !hs && (k >= TO - 1);
               tick(); k++; j++;
            end
            if (hs) begin e_rd = rdv; e_e = 1'b0; end
         end
      end
      for (int r = 0; r <= d3; r++) begin
         background();
         mst__fsm__ack_rdy = (r == d3);
         exp_resp(e_rd, e_e);
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      background();
      mst__fsm__req_vld = 1'b0;
      exp_idle();
      chk_en = 1'b1;
      @(negedge clk); #1;
      chk("reset_req_rdy", 64'(fsm__mst__req_rdy), 64'(1));
      chk("reset_ack_rdy", 64'(fsm__slv__ack_rdy), 64'hF);
      chk("reset_ack_vld", 64'(fsm__mst__ack_vld), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      idle_gap(2);

      // Read slave 2: accept T0, master ack at T3.
      run_txn(4'b0100, 1'b0, 1'b0, 0, 0, 0, 32'hA5A5_0001);
      chk("t1_latency", 64'(ack_cyc - acc_cyc), 64'(3));
      chk("t1_rd_data", 64'(ack_data), 64'hA5A5_0001);
      chk("t1_err",     64'(ack_err), 64'(0));
      idle_gap(1);

      // Write slave 0 with the slave stalling 5 cycles.
      run_txn(4'b0001, 1'b0, 1'b1, 5, 0, 0, 32'h0000_0042);
      chk("t2_req_vld_cycles", 64'(req_hi_cnt), 64'(6));
      idle_gap(1);

      // Decode miss answers straight away with an error.
      run_txn(4'b0010, 1'b1, 1'b0, 0, 0, 0, 32'hFFFF_FFFF);
      chk("t3_latency",   64'(ack_cyc - acc_cyc), 64'(1));
      chk("t3_err",       64'(ack_err), 64'(1));
      chk("t3_rd_data",   64'(ack_data), 64'(0));
      chk("t3_no_slv_req", 64'(req_hi_cnt), 64'(0));
      idle_gap(1);

      // Slave 0 never acks: error 8 cycles after REQ entry, then a late ack is drained.
      run_txn(4'b0001, 1'b0, 1'b0, 0, -1, 0, 32'h0);
      chk("t4_latency", 64'(ack_cyc - acc_cyc), 64'(9));
      chk("t4_err",     64'(ack_err), 64'(1));
      background();
      mst__fsm__req_vld = 1'b0;
      slv__fsm__ack_vld[0] = 1'b1;
      slv__fsm__rd_data[DW-1:0] = 32'hDEAD_BEEF;
      exp_idle();
      tick();
      run_txn(4'b0001, 1'b0, 1'b0, 0, 1, 0, 32'h1234_5678);
      chk("t4_next_rd_data", 64'(ack_data), 64'h1234_5678);
      chk("t4_next_err",     64'(ack_err), 64'(0));

      // Master holds off ack_rdy for 4 cycles.
      run_txn(4'b1000, 1'b0, 1'b0, 1, 2, 4, 32'h0BAD_F00D);
      chk("t5_ack_hold_cycles", 64'(ack_hi_cnt), 64'(5));
      chk("t5_rd_data", 64'(ack_data), 64'h0BAD_F00D);

      // sync_reset while in ACK aborts without a master ack.
      t_oh = 4'b0010;
      background();
      mst__fsm__req_vld = 1'b1; mst__fsm__wr_en = 1'b0; mst__fsm__rd_en = 1'b1;
      dec__fsm__slv_sel = 4'b0010; dec__fsm__miss = 1'b0;
      t_addr = mst__fsm__addr; t_wd = mst__fsm__wr_data; t_we = 1'b0;
      exp_idle(); tick();
      background(); slv__fsm__req_rdy[1] = 1'b1; exp_slv(1'b1); tick();
      background(); slv__fsm__ack_vld[1] = 1'b0; mst__fsm__sync_reset = 1'b1; exp_slv(1'b0); tick();
      background(); mst__fsm__req_vld = 1'b0; slv__fsm__ack_vld[1] = 1'b1; exp_idle(); tick();
      idle_gap(2);
      chk("t6_sync_no_ack", 64'(ack_hi_cnt), 64'(0));

      // Async reset while in REQ.
      background();
      mst__fsm__req_vld = 1'b1; mst__fsm__wr_en = 1'b1; mst__fsm__rd_en = 1'b0;
      dec__fsm__slv_sel = 4'b0010; dec__fsm__miss = 1'b0;
      t_addr = mst__fsm__addr; t_wd = mst__fsm__wr_data; t_we = 1'b1;
      exp_idle(); tick();
      background(); slv__fsm__req_rdy[1] = 1'b0; exp_slv(1'b1);
      @(negedge clk); #1;
      rst = 1'b1;
      exp_idle();
      #1;
      chk("t6_rst_req_vld", 64'(fsm__slv__req_vld), 64'(0));
      chk("t6_rst_addr",    64'(fsm__slv__addr), 64'(0));
      chk("t6_rst_req_rdy", 64'(fsm__mst__req_rdy), 64'(1));
      @(posedge clk); #1;
      rst = 1'b0;
      background(); mst__fsm__req_vld = 1'b0; exp_idle(); tick();
      idle_gap(1);
      chk("t6_rst_no_ack", 64'(ack_hi_cnt), 64'(0));

      // Randomized traffic, including multi-hot selects, misses and timeouts.
      for (int n = 0; n < 200; n++) begin
         logic [NS-1:0] s;
         logic m;
         int a, b, c;
         s = NS'($urandom);
         m = ($urandom_range(0, 7) == 0);
         a = $urandom_range(0, 3);
         b = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         if ($urandom_range(0, 15) == 0) b = -1;
         if ($urandom_range(0, 15) == 0) a = -1;
         run_txn(s, m, 1'($urandom), a, b, c, $urandom);
         idle_gap($urandom_range(0, 2));
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
